// File: rtl/skid_reg.sv
// skid_reg: two-entry register slice with fully registered valid/ready and synchronous flush
`ifndef REG_DLY
`define REG_DLY
`endif

module skid_reg #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic [1:0]            cnt_o
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  in_fire, out_fire, main_en, skid_en, main_from_skid;

    assign valid_o  = state_q != EMPTY;
    assign ready_o  = state_q != FULL;
    assign cnt_o    = state_q;
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;

    // next occupancy and register enables; flush overrides every transfer in the same cycle
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                main_en = in_fire;
                state_d = in_fire ? ONE : EMPTY;
            end
            ONE: begin
                main_en = in_fire & out_fire;
                skid_en = in_fire & ~out_fire;
                state_d = (in_fire & ~out_fire) ? FULL : (~in_fire & out_fire) ? EMPTY : ONE;
            end
            FULL: begin
                main_en        = out_fire;
                main_from_skid = out_fire;
                state_d        = out_fire ? ONE : FULL;
            end
            default: state_d = EMPTY;
        endcase
        if (flush_i) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    // occupancy register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    // payload registers, written only when an entry actually moves
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dat_o  <= '0;
            skid_q <= '0;
        end else begin
            if (main_en) dat_o  <= `REG_DLY (main_from_skid ? skid_q : dat_i);
            if (skid_en) skid_q <= `REG_DLY dat_i;
        end
    end

`ifndef SV_ASSRT_DISABLE
    a_handshake_known: assert property (@(posedge clk_i) disable iff (!rst_n_i) !$isunknown({valid_i, ready_i}));
`endif
endmodule

// File: doc/skid_reg.md
SKID_REG -- requirements
Module: skid_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, payload width in bits (>= 1).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush_i  input  1  synchronous clear of all buffered entries.
REQ-005 SHALL have port valid_i  input  1  upstream payload valid.
REQ-006 SHALL have port ready_o  output  1  slice can accept a payload this cycle.
REQ-007 SHALL have port dat_i  input  DATA_WIDTH  upstream payload.
REQ-008 SHALL have port valid_o  output  1  downstream payload valid.
REQ-009 SHALL have port ready_i  input  1  downstream accepts payload this cycle.
REQ-010 SHALL have port dat_o  output  DATA_WIDTH  downstream payload.
REQ-011 SHALL have port cnt_o  output  2  number of buffered entries (0..2).

Function
REQ-012 SHALL implement a two-entry register slice: a main register driving dat_o and a skid register holding one overflow entry.
REQ-013 SHALL hold state EMPTY (0 entries), ONE (main valid) or FULL (main and skid valid); cnt_o SHALL equal 0/1/2 respectively.
REQ-014 SHALL define in_fire = valid_i & ready_o and out_fire = valid_o & ready_i.
REQ-015 SHALL drive valid_o = (state != EMPTY) and ready_o = (state != FULL), both directly from registered state; no combinational path from valid_i, ready_i or dat_i to any output.
REQ-016 EMPTY: in_fire -> main <= dat_i, go ONE; otherwise stay.
REQ-017 ONE: in_fire & out_fire -> main <= dat_i, stay ONE; in_fire only -> skid <= dat_i, go FULL; out_fire only -> go EMPTY; neither -> stay.
REQ-018 FULL: out_fire -> main <= skid, go ONE; otherwise stay; no input is accepted in FULL.
REQ-019 SHALL preserve strict FIFO order; no payload shall be dropped or duplicated except by flush_i or reset.
REQ-020 Latency: a payload accepted in cycle N SHALL appear on dat_o with valid_o high no earlier than cycle N+1; sustained throughput SHALL be one transfer per cycle when ready_i stays high.
REQ-021 dat_o SHALL remain stable while valid_o = 1 and ready_i = 0.
REQ-022 flush_i = 1 SHALL force state EMPTY next cycle regardless of in_fire/out_fire in the same cycle; a payload presented in that cycle is discarded; data register contents are don't-care after flush.
REQ-023 Register contents SHALL only be written on in_fire or FULL->ONE transfer (clock enable), not every cycle.
REQ-024 Behaviour with valid_i = X or ready_i = X SHALL be flagged by an assertion unless SV_ASSRT_DISABLE is defined.

Reset
REQ-025 On rst_n_i = 0 the block SHALL immediately (asynchronously) enter EMPTY: valid_o = 0, ready_o = 1, cnt_o = 0, dat_o = 0, skid register = 0.
REQ-026 Reset asserted mid-operation SHALL discard all buffered entries; first acceptance after release SHALL be on the first rising edge with rst_n_i = 1 and valid_i = 1.
REQ-027 Payload register updates SHALL use the codebase register delay macro on non-reset assignments.

Verification
REQ-028 Reset then valid_i=1, dat_i=0xA5, ready_i=1 (DATA_WIDTH=8) -> next cycle valid_o=1, dat_o=0xA5, cnt_o=1.
REQ-029 Stream 0x01..0x10 with ready_i=1 continuously -> 16 outputs in order, one per cycle, ready_o never low, cnt_o=1 throughout stream.
REQ-030 ready_i=0, push 0x11 then 0x22 -> cnt_o=2, ready_o=0, dat_o=0x11 held; 0x33 offered is not accepted; raise ready_i -> outputs 0x11, 0x22, 0x33 in order.
REQ-031 FULL state, flush_i=1 with valid_i=1, dat_i=0x44 -> next cycle cnt_o=0, valid_o=0, ready_o=1; 0x44 never appears.
REQ-032 FULL state, assert rst_n_i=0 between clock edges -> valid_o=0, ready_o=1, cnt_o=0, dat_o=0 without waiting for a clock edge.
REQ-033 Random valid_i/ready_i (50%) for 10000 cycles against scoreboard -> zero order/loss mismatches, no output combinationally dependent on ready_i.
